radar_window_sequencer: RTL and testbench
=========================================

Name: radar_window_sequencer

Overview:
- Streaming controller that builds the 5-point, edge-clamped sliding windows consumed by the radar noise-reducer coordinate splitter and median stage.
- Accepts 128-bit radar points, each {W[127:96], Z[95:64], Y[63:32], X[31:0]}, one per handshake, framed by in_last.
- Emits exactly one window per input point. Window k is centred on point k and carries points k-2..k+2; indices are clamped to [0, N-1] at the frame edges.
- Sits between the radar point ingress FIFO and the splitter.

Parameters:
- DATA_W, 128, width of one radar point.
- CNT_W, 16, width of the frame-done counter.

Ports:
- clk, input, 1, system clock. All logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, input point valid.
- in_ready, output, 1, sequencer can accept a point.
- in_data, input, DATA_W, radar point.
- in_last, input, 1, marks the last point of the frame. Qualified by in_valid.
- win_valid, output, 1, window_out holds a valid window.
- win_ready, input, 1, downstream accepts the window.
- window_out, output, DATA_W x5 (unpacked [0:4]), window. Index 2 is the centre point; index 4 is the newest.
- win_last, output, 1, marks the final window of a frame.
- busy, output, 1, high when the state is not IDLE.
- frames_done, output, CNT_W, count of completed frames. Wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE; shift register, window_out, win_valid, win_last, frames_done and the event counter all go to 0.
  - Any partial frame is discarded with no trailing windows.
  - rst takes priority over every other event in the same cycle.
- Terminology:
  - An "accept" is in_valid & in_ready.
  - A "window emit" is win_valid & win_ready.
  - slot_free = !win_valid || win_ready.
- Internal storage: a 5-entry shift register S[0:4] and a saturating event counter ev (0..3).
- States: IDLE, STREAM, FLUSH1, FLUSH2.
- in_ready = (state is IDLE or STREAM) && slot_free. It is 0 in both FLUSH states.
- IDLE:
  - On accept: load all five entries S[0..4] with in_data and set ev=1.
  - If in_last=1 go to FLUSH1; otherwise go to STREAM.
- STREAM:
  - On accept: shift S[0]<=S[1] .. S[3]<=S[4], S[4]<=in_data, and increment ev (saturating at 3).
  - If in_last=1 go to FLUSH1.
- FLUSH1, FLUSH2 (pad steps):
  - When slot_free: shift with S[4]<=S[4] (replicate the newest point) and increment ev.
  - FLUSH1 then goes to FLUSH2; FLUSH2 then goes to IDLE.
  - With slot_free=0 the state holds and no shift occurs.
- Window generation:
  - Any shift or load that leaves ev==3 after the update registers window_out <= the updated S and sets win_valid=1 on the next edge. Latency is one cycle from the causing accept or pad.
  - win_last=1 only on the window produced by the FLUSH2 step.
- Window count: a frame of N points produces N+2 events and therefore exactly N windows, including N=1 and N=2.
  - N=1 gives window [p0,p0,p0,p0,p0].
  - N=2 gives windows [p0,p0,p0,p1,p1] then [p0,p0,p1,p1,p1].
- Output slot:
  - win_valid clears on a window emit unless a new window is produced in the same cycle.
  - window_out and win_last are stable while win_valid=1 and win_ready=0.
- frames_done increments by one on the window emit that has win_last=1.
- in_last is ignored unless in_valid is high. No partial-frame timeout exists.
- Back-to-back frames: the first point of the next frame can be accepted in the cycle after FLUSH2 completes, subject to slot_free. There is no bubble beyond the two pad cycles.

Test Plan:
- Frame of 5 points X=1..5 (W/Y/Z=0), win_ready=1.
  - Expect 5 windows, X centre values 1,2,3,4,5.
  - Window0 X = [1,1,1,2,3]; window4 X = [3,4,5,5,5] with win_last=1.
  - frames_done=1.
- Single-point frame in_data=128'hA, in_last=1.
  - Expect exactly one window, all five entries 128'hA, win_last=1.
  - in_ready=0 for 2 cycles.
- Two-point frame X=7,9.
  - Expect windows [7,7,7,9,9] and [7,7,9,9,9]; win_last only on the second.
- Backpressure: 8-point frame with win_ready toggled 1,0,0,1 repeating.
  - Expect no lost or duplicated windows and window_out stable while stalled.
  - in_ready=0 whenever win_valid&!win_ready.
  - Centre sequence equals the input order.
- Reset mid-frame: rst=1 after 3 points of a frame.
  - Expect the next cycle to show win_valid=0, busy=0, frames_done unchanged from 0.
  - A following 3-point frame yields exactly 3 correct windows.
- Back-to-back frames of 3 and 4 points, in_valid held high.
  - Expect 7 windows; the second frame's window0 contains no points from frame 1.
  - frames_done=2.

Source files
------------

// File: rtl/radar_window_sequencer.sv
// Builds one 5-point edge-clamped sliding window per input radar point.
// Two pad steps at the end of each frame replicate the newest point.
// state  | meaning
// IDLE   | waiting for the first point of a frame
// STREAM | accepting points of the current frame
// FLUSH1 | first pad step after the last point
// FLUSH2 | second pad step; produces the last window of the frame
module radar_window_sequencer #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DATA_W-1:0] window_out [0:4],
  output logic              win_last,
  output logic              busy,
  output logic [CNT_W-1:0]  frames_done
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH1, FLUSH2} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] s_q   [0:4];
  logic [DATA_W-1:0] s_nxt [0:4];
  logic [1:0]        ev_q, ev_nxt, ev_inc;
  logic              slot_free, accept, pad, produce;

  assign slot_free = !win_valid || win_ready;
  assign in_ready  = ((state == IDLE) || (state == STREAM)) && slot_free;
  assign accept    = in_valid && in_ready;
  assign pad       = ((state == FLUSH1) || (state == FLUSH2)) && slot_free;
  assign busy      = (state != IDLE);
  assign ev_inc    = (ev_q == 2'd3) ? 2'd3 : ev_q + 2'd1;

  always_comb begin
    state_nxt = state;
    ev_nxt    = ev_q;
    for (int i = 0; i < 5; i++) s_nxt[i] = s_q[i];
    case (state)
      IDLE: begin
        if (accept) begin
          for (int i = 0; i < 5; i++) s_nxt[i] = in_data;
          ev_nxt    = 2'd1;
          state_nxt = in_last ? FLUSH1 : STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          for (int i = 0; i < 4; i++) s_nxt[i] = s_q[i+1];
          s_nxt[4] = in_data;
          ev_nxt   = ev_inc;
          if (in_last) state_nxt = FLUSH1;
        end
      end
      FLUSH1, FLUSH2: begin
        // pad step: newest point is replicated into the tail
        if (pad) begin
          for (int i = 0; i < 4; i++) s_nxt[i] = s_q[i+1];
          s_nxt[4]  = s_q[4];
          ev_nxt    = ev_inc;
          state_nxt = (state == FLUSH1) ? FLUSH2 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    produce = (accept || pad) && (ev_nxt == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ev_q        <= 2'd0;
      win_valid   <= 1'b0;
      win_last    <= 1'b0;
      frames_done <= '0;
      for (int i = 0; i < 5; i++) begin
        s_q[i]        <= '0;
        window_out[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      ev_q  <= ev_nxt;
      for (int i = 0; i < 5; i++) s_q[i] <= s_nxt[i];
      if (win_valid && win_ready && win_last) frames_done <= frames_done + CNT_W'(1);
      // a new window only appears when the slot is free, so a stalled one is never overwritten
      if (produce) begin
        for (int i = 0; i < 5; i++) window_out[i] <= s_nxt[i];
        win_valid <= 1'b1;
        win_last  <= (state == FLUSH2);
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_radar_window_sequencer.sv
// Randomized bench for radar_window_sequencer against a clamped-index window model.
module tb_radar_window_sequencer;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_last;
  logic          win_valid, win_ready, win_last, busy;
  logic [DW-1:0] in_data;
  logic [DW-1:0] window_out [0:4];
  logic [15:0]   frames_done;

  radar_window_sequencer #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .win_valid(win_valid),
    .win_ready(win_ready), .window_out(window_out), .win_last(win_last),
    .busy(busy), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  typedef struct {logic [639:0] w; logic last;} win_t;

  win_t         exp_q[$];
  logic [128:0] pt_q[$];
  win_t         mon_e;
  int           n_chk = 0, n_pass = 0, exp_frames = 0, bp_mode = 0, cyc = 0;
  logic         prev_stall = 1'b0, prev_last = 1'b0;
  logic [639:0] prev_win = '0;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [639:0] cur_win();
    return {window_out[0], window_out[1], window_out[2], window_out[3], window_out[4]};
  endfunction

  // window k of an N-point frame holds points clamp(k-2+j) for j=0..4
  task automatic add_frame(input int n, input logic [127:0] base, input logic [127:0] step,
                           input bit rnd);
    logic [127:0] p[$];
    logic [639:0] w;
    int           idx;
    for (int i = 0; i < n; i++) begin
      p.push_back(rnd ? {$urandom, $urandom, $urandom, $urandom} : base + step * i);
      pt_q.push_back({1'(i == n - 1), p[i]});
    end
    for (int k = 0; k < n; k++) begin
      w = '0;
      for (int j = 0; j < 5; j++) begin
        idx = k - 2 + j;
        if (idx < 0) idx = 0;
        if (idx > n - 1) idx = n - 1;
        w = {w[511:0], p[idx]};
      end
      exp_q.push_back('{w, (k == n - 1)});
    end
  endtask

  task automatic drive_all(input int gap);
    int guard = 0;
    while (pt_q.size() != 0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
      if ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(1));
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = 1'b1;
        {in_last, in_data} = pt_q[0];
      end
      #1;
      if (in_valid && in_ready) void'(pt_q.pop_front());
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("drive_timeout", guard >= 3000, 0);
  endtask

  task automatic wait_drain();
    int t   = 0;
    bit tmo = 1'b0;
    while (exp_q.size() != 0 || win_valid !== 1'b0 || busy !== 1'b0) begin
      @(posedge clk); #3;
      t++;
      if (t > 500) begin tmo = 1'b1; break; end
    end
    chk("drain_timeout", tmo, 0);
    chk("frames_done", frames_done, exp_frames[15:0]);
  endtask

  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (bp_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       win_ready = 1'($urandom_range(1));
        default: win_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", win_valid, 1);
        chk("stall_data", cur_win(), prev_win);
        chk("stall_last", win_last, prev_last);
      end
      if (win_valid === 1'b1 && win_ready === 1'b0) chk("ready_in_stall", in_ready, 0);
      if (win_valid === 1'b1 && win_ready === 1'b1) begin
        chk("win_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("win_data", cur_win(), mon_e.w);
          chk("win_last", win_last, mon_e.last);
          if (mon_e.last) exp_frames++;
        end
      end
      prev_stall = (win_valid === 1'b1) && (win_ready === 1'b0);
      prev_win   = cur_win();
      prev_last  = win_last;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_window", cur_win(), 0);
    chk("rst_in_ready", in_ready, 1);

    add_frame(5, 128'd1, 128'd1, 1'b0);
    drive_all(0);
    wait_drain();

    @(posedge clk); #1;
    add_frame(1, 128'hA, 128'd0, 1'b0);
    pt_q.delete();
    in_valid = 1'b1; in_data = 128'hA; in_last = 1'b1;
    #1 chk("single_rdy_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    #1 chk("single_rdy_f1", in_ready, 0);
    @(posedge clk); #2 chk("single_rdy_f2", in_ready, 0);
    @(posedge clk); #2 chk("single_rdy_back", in_ready, 1);
    wait_drain();

    add_frame(2, 128'd7, 128'd2, 1'b0);
    drive_all(0);
    wait_drain();

    bp_mode = 1;
    add_frame(8, '0, '0, 1'b1);
    drive_all(0);
    wait_drain();
    bp_mode = 0;

    add_frame(3, '0, '0, 1'b1);
    add_frame(4, '0, '0, 1'b1);
    drive_all(0);
    wait_drain();

    bp_mode = 3;
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) pt_q.push_back({1'b0, $urandom, $urandom, $urandom, $urandom});
    drive_all(0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_frames = 0;
    bp_mode = 0;
    @(negedge clk);
    chk("midrst_win_valid", win_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frames", frames_done, 0);
    add_frame(3, '0, '0, 1'b1);
    drive_all(0);
    wait_drain();

    bp_mode = 2;
    repeat (6) add_frame($urandom_range(1, 7), '0, '0, 1'b1);
    drive_all(30);
    wait_drain();
    bp_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
